// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter over a req/ack handshake, with fill level and sticky overflow.
// Define UART_TX_FIFO_CRLF_EN to expand each stored LF into CR LF on the transmitter side.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             wr_req,
    input  logic [7:0]       wr_data,
    output logic             wr_full,
    output logic [LVL_W-1:0] fifo_level,
    output logic             overflow,
    input  logic             ovf_clr,
    output logic             tx_req,
    output logic [7:0]       tx_data,
    input  logic             tx_ready
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr_reg, wr_ptr_next;
    logic [AW:0] rd_ptr_reg, rd_ptr_next;
    logic        overflow_reg, overflow_next;
    logic        empty, full, push, ack, pop;
    logic [7:0]  head;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign head  = mem[rd_ptr_reg[AW-1:0]];
    assign push  = wr_req && !full;
    assign ack   = tx_ready && !empty;

`ifdef UART_TX_FIFO_CRLF_EN
    logic cr_done_reg, cr_done_next;
    logic head_is_lf;

    assign head_is_lf = (head == 8'h0A);
    // The first ack of an LF only consumes the inserted CR; the LF itself stays at the head.
    assign pop        = ack && (!head_is_lf || cr_done_reg);
    assign tx_data    = (head_is_lf && !cr_done_reg) ? 8'h0D : head;

    always_comb begin
        cr_done_next = cr_done_reg;
        if (ack && head_is_lf && !cr_done_reg) begin
            cr_done_next = 1'b1;
        end else if (pop) begin
            cr_done_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            cr_done_reg <= 1'b0;
        end else begin
            cr_done_reg <= cr_done_next;
        end
    end
`else
    assign pop     = ack;
    assign tx_data = head;
`endif

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        overflow_next = overflow_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
        // Full is judged at the start of the cycle, so a same-cycle pop does not save the push.
        if (wr_req && full) begin
            overflow_next = 1'b1;
        end else if (ovf_clr) begin
            overflow_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            overflow_reg <= overflow_next;
        end
    end

    // Storage is not reset; contents are invalidated by clearing the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= wr_data;
        end
    end

    assign wr_full    = full;
    assign fifo_level = wr_ptr_reg - rd_ptr_reg;
    assign overflow   = overflow_reg;
    assign tx_req     = !empty;

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte FIFO sitting directly upstream of the UART transmitter: the CPU/bus side pushes characters with a single-cycle write strobe, and the FIFO drains them into the transmitter using its request/acknowledge handshake. It decouples software from the baud rate, reports fill level and a sticky overflow flag, and can optionally expand LF into CR LF on the fly.

## Interface
- DEPTH, 16, number of byte entries; power of two, ≥ 2
- LVL_W, $clog2(DEPTH)+1, width of level output (derived, do not override)

- clk  in  1  system clock, all logic on rising edge
- reset_  in  1  asynchronous, active-low reset
- wr_req  in  1  push strobe, one byte per cycle when high
- wr_data  in  8  byte to push
- wr_full  out  1  FIFO holds DEPTH entries
- fifo_level  out  LVL_W  current entry count, 0..DEPTH
- overflow  out  1  sticky: a push was attempted while full
- ovf_clr  in  1  clears overflow
- tx_req  out  1  byte available toward transmitter
- tx_data  out  8  byte presented to transmitter
- tx_ready  in  1  one-cycle acknowledge from transmitter: byte taken

## Operation
- Storage: DEPTH×8 array; wr_ptr, rd_ptr each $clog2(DEPTH)+1 bits (extra wrap bit); level = wr_ptr − rd_ptr modulo 2^(LVL_W).
- Full when pointers differ only in MSB; empty when equal. Pointers wrap naturally at 2·DEPTH.
- Push: accepted iff wr_req && !wr_full; writes mem[wr_ptr[low]], increments wr_ptr.
- Push while full: byte dropped, pointers unchanged, overflow set. A pop in the same cycle does not rescue it (wr_full is the start-of-cycle value).
- Pop: on tx_ready while tx_req high, rd_ptr increments (subject to CRLF rule below). tx_ready while empty is ignored.
- Simultaneous accepted push and pop: level unchanged, both pointers advance.
- tx_req = !empty. tx_data = mem[rd_ptr[low]], combinational read of the head; holds stable from tx_req rise until tx_ready (transmitter samples it at its start bit, acknowledges one cycle later).
- overflow: set on dropped push, cleared by ovf_clr; set wins when both in same cycle.

## Timing
- Reset values: wr_full 0, fifo_level 0, overflow 0, tx_req 0, tx_data = array content (don't care, X allowed), pointers 0, CRLF state idle.
- Push to empty FIFO at edge N: tx_req and tx_data valid after edge N (visible in cycle N+1).
- Pop at edge M: next head (or tx_req low) visible in cycle M+1.
- wr_full/fifo_level update the cycle after the push/pop edge.
- Reset asserted mid-operation: all contents discarded immediately, outputs go to reset values asynchronously.

## Configuration
- UART_TX_FIFO_CRLF_EN defined: one-bit state cr_done. When head byte is 0x0A and cr_done=0, tx_data presents 0x0D; tx_ready sets cr_done without popping. With cr_done=1, tx_data presents 0x0A; tx_ready pops and clears cr_done. Level/full count stored bytes only. Reset clears cr_done.
- Not defined: no state added, tx_data is always the head byte, every tx_ready pops.

## Test plan
- Reset, push 0x41,0x42,0x43 back-to-back, ack each with a tx_ready pulse 10 cycles after the prior -> tx_data 0x41,0x42,0x43 in order, fifo_level 3→0, tx_req low after third ack.
- Push DEPTH+1 bytes with no acks -> wr_full=1 at level 16, 17th byte dropped, overflow=1; ovf_clr pulse -> overflow=0; drain returns first 16 bytes intact.
- Full FIFO, wr_req and tx_ready in same cycle -> pop occurs, push dropped, overflow=1, level 15.
- Level 5, push and pop same cycle 40 times -> level stays 5, pointers wrap past 2·DEPTH, data order preserved.
- With UART_TX_FIFO_CRLF_EN: push 0x48,0x0A -> transmitter sees 0x48,0x0D,0x0A over three acks, level 2→1→1→0; without macro -> 0x48,0x0A.
- Reset asserted while level 7 and a byte unacked -> tx_req falls asynchronously, level 0, overflow 0; subsequent push of 0x55 emerges first.
